// File: rtl/sram_like_responder_pkg.sv
// Shared types and helpers for the sram-like responder.
//   size_e       : request size codes (byte / half / word; code 3 also means word)
//   req_t        : request bundle captured at the address handshake
//   run_state_e  : post-reset gating of the address phase
//   byte_strobe  : per-byte write enables from size and addr[1:0]
//   lfsr_next    : one step of the x^8+x^6+x^5+x^4+1 stall LFSR
package sram_like_responder_pkg;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeWord3 = 2'd3
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [0:0] {
    StHold,
    StRun
  } run_state_e;

  localparam logic [7:0] LfsrSeed = 8'hA5;

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size_e'(size))
      SizeByte: strb = 4'b0001 << lo;
      SizeHalf: strb = 4'b0011 << {lo[1], 1'b0};
      default:  strb = 4'hF;
    endcase
    return strb;
  endfunction

  // Fibonacci form: taps at bits 8,6,5,4 of the polynomial.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/sram_like_responder_req_fifo.sv
// In-order request FIFO with a per-entry latency countdown.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (flushes all entries)
//   push_i         : capture push_data_i into the tail; countdown starts at Latency-1
//   pop_i          : retire the head (caller only pops when head_ready_o)
//   head_o         : head request bundle
//   head_valid_o   : head slot holds a request
//   head_ready_o   : head is valid and its countdown has expired
//   count_o        : number of occupied entries
// All valid entries age in parallel, so a back-to-back stream retires one per cycle.
module sram_like_responder_req_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned Latency = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  req_t                       push_data_i,
  input  logic                       pop_i,
  output req_t                       head_o,
  output logic                       head_valid_o,
  output logic                       head_ready_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CdW  = (Latency > 1) ? $clog2(Latency) : 1;

  req_t            data_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [CdW-1:0]  cd_q [Depth];
  logic [CdW-1:0]  cd_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    for (int i = 0; i < Depth; i++) begin
      cd_d[i] = (valid_q[i] && (cd_q[i] != '0)) ? cd_q[i] - CdW'(1) : cd_q[i];
    end
    if (pop_i) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PtrW'(1);
    end
    // The push slot never aliases the popped slot: push is blocked when full.
    if (push_i) begin
      valid_d[wptr_q] = 1'b1;
      cd_d[wptr_q]    = CdW'(Latency - 1);
      wptr_d          = wptr_q + PtrW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < Depth; i++) begin
        cd_q[i] <= cd_d[i];
      end
    end
  end

  // Payload needs no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wptr_q] <= push_data_i;
    end
  end

  assign head_o       = data_q[rptr_q];
  assign head_valid_o = valid_q[rptr_q];
  assign head_ready_o = valid_q[rptr_q] && (cd_q[rptr_q] == '0);
  assign count_o      = count_q;

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of an sram-like bus: req/addr_ok address phase, data_ok/rdata data phase.
// Holds up to MAX_OUTSTANDING requests and completes them strictly in order, each no
// earlier than READ_LATENCY cycles after its address handshake.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (memory array is not cleared)
//   req_i      : master request valid
//   wr_i       : 1 = write, 0 = read
//   size_i     : 0 byte, 1 half, 2/3 word
//   addr_i     : byte address, bits [ADDR_WIDTH-1:0] decoded
//   wdata_i    : write data, lane-aligned to addr_i[1:0]
//   addr_ok_o  : address phase accepted when req_i && addr_ok_o
//   data_ok_o  : one-cycle pulse, head request completed
//   rdata_o    : read word for a completing read, zero for a completing write
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RAND_STALL      = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned WordW = ADDR_WIDTH - 2;
  localparam int unsigned Words = 2 ** WordW;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING) + 1;

  run_state_e      state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            data_ok_q, data_ok_d;
  logic [31:0]     rdata_q, rdata_d;

  req_t            push_data;
  req_t            head;
  logic            head_valid;
  logic            head_ready;
  logic [CntW-1:0] count;
  logic            push;
  logic            pop;
  logic [WordW-1:0] head_idx;
  logic [3:0]      head_strb;

  logic [31:0]     mem_q [Words];

  // Address phase opens only one edge after reset release. Everything below is
  // registered state, so there is no combinational path from req_i to addr_ok_o.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StHold;
    endcase
  end

  assign lfsr_d    = (RAND_STALL != 0) ? lfsr_next(lfsr_q) : lfsr_q;

  assign addr_ok_o = (state_q == StRun) &&
                     (count < CntW'(MAX_OUTSTANDING)) &&
                     ((RAND_STALL == 0) || lfsr_q[0]);

  assign push      = req_i && addr_ok_o;
  assign push_data = '{wr: wr_i, size: size_i, addr: addr_i, wdata: wdata_i};

  sram_like_responder_req_fifo #(
    .Depth   (MAX_OUTSTANDING),
    .Latency (READ_LATENCY)
  ) u_req_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .head_ready_o (head_ready),
    .count_o      (count)
  );

  // The head retires as soon as its countdown expires; data_ok follows one edge later.
  assign pop       = head_ready;
  assign head_idx  = head.addr[ADDR_WIDTH-1:2];
  assign head_strb = byte_strobe(head.size, head.addr[1:0]);

  always_comb begin
    data_ok_d = pop;
    rdata_d   = '0;
    if (pop && !head.wr) begin
      rdata_d = mem_q[head_idx];
    end
  end

  // Writes commit at in-order completion, so a younger read of the same word sees them.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (pop && head.wr && head_strb[b]) begin
        mem_q[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StHold;
      lfsr_q    <= LfsrSeed;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;

  logic unused_head;
  assign unused_head = ^{head_valid, head.addr[31:ADDR_WIDTH]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. Two instances: one plain (latency 2), one with random
// address-phase stalls and latency 5 so that the FIFO fills. A per-instance model keeps a
// list of accepted requests with their due cycle and a word array updated in order.
module tb_sram_like_responder;

  localparam int unsigned Aw     = 16;
  localparam int unsigned MaxOut = 4;
  localparam int          Lat0   = 2;
  localparam int          Lat1   = 5;
  localparam int          QDepth = 64;
  localparam int          Words  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_responder #(
    .ADDR_WIDTH(Aw), .READ_LATENCY(Lat0), .MAX_OUTSTANDING(MaxOut), .RAND_STALL(0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .wr_i(wr[0]), .size_i(size[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .addr_ok_o(addr_ok[0]), .data_ok_o(data_ok[0]),
    .rdata_o(rdata[0])
  );

  sram_like_responder #(
    .ADDR_WIDTH(Aw), .READ_LATENCY(Lat1), .MAX_OUTSTANDING(MaxOut), .RAND_STALL(1)
  ) u_dut_stall (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .wr_i(wr[1]), .size_i(size[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .addr_ok_o(addr_ok[1]), .data_ok_o(data_ok[1]),
    .rdata_o(rdata[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic        ready_m;
  logic [7:0]  lfsr_m;
  logic        q_wr [2][QDepth];
  logic [1:0]  q_size [2][QDepth];
  logic [31:0] q_addr [2][QDepth];
  logic [31:0] q_wdata [2][QDepth];
  int          q_due [2][QDepth];
  int          hd [2];
  int          tl [2];
  logic [31:0] mmem [2][Words];
  logic        known [2][Words];
  logic [31:0] last_rd [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? Lat0 : Lat1;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Byte-lane merge from the size rules: byte -> one lane, half -> lane pair, word -> all.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] r;
    logic        en;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sz == 2'd0)      en = (b == int'(lo));
      else if (sz == 2'd1) en = ((b / 2) == (int'(lo) / 2));
      else                 en = 1'b1;
      if (en) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_m <= 1'b0;
      lfsr_m  <= 8'hA5;
    end else begin
      ready_m <= 1'b1;
      lfsr_m  <= lfsr_step(lfsr_m);
    end
  end

  always @(negedge clk) begin
    logic        due_now;
    logic        exp_ok;
    logic [31:0] exp_rd;
    int          h;
    int          w;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        check_eq("rst_addr_ok", addr_ok[d], 1'b0);
        check_eq("rst_data_ok", data_ok[d], 1'b0);
        check_eq("rst_rdata", rdata[d], 32'h0);
        hd[d] = tl[d];
      end else begin
        h       = hd[d] % QDepth;
        due_now = (tl[d] != hd[d]) && (q_due[d][h] == cyc);
        check_eq("data_ok", data_ok[d], due_now);
        if (due_now) begin
          w = int'(q_addr[d][h][7:2]);
          if (q_wr[d][h]) begin
            exp_rd      = 32'h0;
            mmem[d][w]  = merge(mmem[d][w], q_wdata[d][h], q_size[d][h], q_addr[d][h][1:0]);
            known[d][w] = 1'b1;
          end else begin
            exp_rd = mmem[d][w];
          end
          if (q_wr[d][h] || known[d][w]) check_eq("rdata", rdata[d], exp_rd);
          last_rd[d] = rdata[d];
          hd[d]++;
        end
        exp_ok = ready_m && ((tl[d] - hd[d]) < int'(MaxOut)) && ((d == 0) || lfsr_m[0]);
        check_eq("addr_ok", addr_ok[d], exp_ok);
        if (req[d] && addr_ok[d]) begin
          h             = tl[d] % QDepth;
          q_wr[d][h]    = wr[d];
          q_size[d][h]  = size[d];
          q_addr[d][h]  = addr[d];
          q_wdata[d][h] = wdata[d];
          q_due[d][h]   = cyc + 1 + lat_of(d);
          tl[d]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int d, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    req[d] = 1'b1; wr[d] = w; size[d] = s; addr[d] = a; wdata[d] = wd;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = addr_ok[d];
      @(posedge clk);
      #1;
      n++;
    end
    req[d] = 1'b0;
    check_eq("issue_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random_ops(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 2));
      issue(d, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
            32'($urandom_range(0, 255)), $urandom);
    end
  endtask

  logic [31:0] got [4];
  int          at [4];
  int          nseen;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0; addr[d] = '0; wdata[d] = '0;
      hd[d] = 0; tl[d] = 0; last_rd[d] = '0;
      for (int i = 0; i < Words; i++) known[d][i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload a known pattern into both instances.
    fork
      begin for (int i = 0; i < Words; i++) issue(0, 1'b1, 2'd2, 32'(i * 4), pat(i)); end
      begin for (int i = 0; i < Words; i++) issue(1, 1'b1, 2'd2, 32'(i * 4), pat(i)); end
    join
    idle(10);

    // Single read, exact latency.
    issue(0, 1'b1, 2'd2, 32'h10, 32'h1234_5678);
    idle(3);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0);
    @(negedge clk); check_eq("t1_lat_e0", data_ok[0], 1'b0);
    @(negedge clk); check_eq("t1_lat_e1", data_ok[0], 1'b0);
    @(negedge clk); check_eq("t1_lat_e2", data_ok[0], 1'b1);
    check_eq("t1_rdata", rdata[0], 32'h1234_5678);
    idle(3);

    // Four back-to-back reads complete on consecutive cycles, in order.
    nseen = 0;
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 2'd2, 32'(i * 4), 32'h0); end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (data_ok[0]) begin
            if (nseen < 4) begin got[nseen] = rdata[0]; at[nseen] = cyc; end
            nseen++;
          end
        end
      end
    join
    check_eq("t2_count", nseen, 4);
    check_eq("t2_span", at[3] - at[0], 3);
    for (int i = 0; i < 4; i++) check_eq("t2_order", got[i], pat(i));
    idle(3);

    // Byte write merges into an existing word.
    issue(0, 1'b1, 2'd2, 32'h20, 32'hFFFF_FFFF);
    issue(0, 1'b1, 2'd0, 32'h21, 32'h0000_AB00);
    issue(0, 1'b0, 2'd2, 32'h20, 32'h0);
    repeat (4) @(negedge clk);
    check_eq("t3_rdata", last_rd[0], 32'hFFFF_ABFF);
    idle(2);

    // Read right behind a write to the same word sees the new data.
    issue(0, 1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd2, 32'h40, 32'h0);
    repeat (4) @(negedge clk);
    check_eq("t4_rdata", last_rd[0], 32'hDEAD_BEEF);
    idle(2);

    // Reset with requests in flight: they vanish without data_ok.
    for (int i = 0; i < 3; i++) issue(0, 1'b0, 2'd2, 32'(i * 4), 32'h0);
    rst_n = 1'b0;
    @(negedge clk); check_eq("t5_addr_ok_rst", addr_ok[0], 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    nseen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (data_ok[0]) nseen++;
    end
    check_eq("t5_no_data_ok", nseen, 0);
    check_eq("t5_reopen", addr_ok[0], 1'b1);
    idle(1);

    // Random traffic on both instances, stalled one filling its FIFO.
    fork
      random_ops(0, 80);
      random_ops(1, 120);
    join
    idle(20);
    check_eq("drain0", tl[0] - hd[0], 0);
    check_eq("drain1", tl[1] - hd[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
